ifu_axi_fetch: RTL and testbench

IFU_AXI_FETCH -- requirements
Module: ifu_axi_fetch

---
 rtl/ifu_axi_fetch.sv | 169 ++++++++++++++++
 tb/tb_ifu_axi_fetch.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_axi_fetch.sv
// rtl/ifu_axi_fetch.sv - AXI-lite instruction fetch unit with credit-limited in-order response buffer
// Optional feature: define IFU_FETCH_ERR_EN to add ifu_rresp_i / if_resp_err_o per-instruction error status
module ifu_axi_fetch #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic [ADDR_WIDTH-1:0] if_req_pc_i,
  input  logic                  if_req_valid_i,
  output logic                  if_req_ready_o,
  output logic [DATA_WIDTH-1:0] if_resp_inst_o,
  output logic                  if_resp_valid_o,
  input  logic                  if_resp_ready_i,
`ifdef IFU_FETCH_ERR_EN
  input  logic [1:0]            ifu_rresp_i,
  output logic                  if_resp_err_o,
`endif
  output logic                  ifu_arvalid_o,
  input  logic                  ifu_arready_i,
  output logic [ADDR_WIDTH-1:0] ifu_araddr_o,
  input  logic                  ifu_rvalid_i,
  input  logic [DATA_WIDTH-1:0] ifu_rdata_i,
  output logic                  ifu_rready_o
);

  // Index bits for the buffer; a DEPTH of 1 still needs one index bit to be legal
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Wide enough for pending + inflight + buffered (at most 17)
  localparam int CW = 5;
  localparam logic [CW-1:0] ONE = CW'(1);
`ifdef IFU_FETCH_ERR_EN
  localparam int EW = DATA_WIDTH + 1;
`else
  localparam int EW = DATA_WIDTH;
`endif

  typedef enum logic {IDLE = 1'b0, ADDR = 1'b1} ar_state_e;

  ar_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [CW-1:0]         inflight_q, inflight_d;
  logic [CW-1:0]         drop_cnt_q, drop_cnt_d;
  logic [IW:0]           wr_ptr_q, wr_ptr_d;
  logic [IW:0]           rd_ptr_q, rd_ptr_d;
  logic [EW-1:0]         mem_q [DEPTH];

  logic          ar_pending, ar_hs, r_hs, req_acc, push, pop;
  logic [CW-1:0] fifo_count, credits;
  logic          fifo_valid;
  logic [EW-1:0] wdata, head;

  // Pointer advance with wrap modulo DEPTH; the top bit flips on every wrap so full and empty differ
  function automatic logic [IW:0] ptr_inc(input logic [IW:0] p);
    if (p[IW-1:0] == IW'(DEPTH - 1)) begin
      ptr_inc = {~p[IW], {IW{1'b0}}};
    end else begin
      ptr_inc = {p[IW], p[IW-1:0] + 1'b1};
    end
  endfunction

`ifdef IFU_FETCH_ERR_EN
  assign wdata = {(ifu_rresp_i != 2'b00), ifu_rdata_i};
`else
  assign wdata = ifu_rdata_i;
`endif

  // Handshakes, credit accounting and buffer occupancy
  always_comb begin
    if (wr_ptr_q[IW] == rd_ptr_q[IW]) begin
      fifo_count = CW'(wr_ptr_q[IW-1:0]) - CW'(rd_ptr_q[IW-1:0]);
    end else begin
      fifo_count = CW'(DEPTH) - CW'(rd_ptr_q[IW-1:0]) + CW'(wr_ptr_q[IW-1:0]);
    end
    fifo_valid = (fifo_count != '0);
    ar_pending = (state_q == ADDR);
    ar_hs      = ar_pending & ifu_arready_i;
    // A beat with nothing outstanding (e.g. stale traffic after reset) is ignored
    r_hs       = ifu_rvalid_i & ifu_rready_o & (inflight_q != '0);
    credits    = CW'(ar_pending) + inflight_q + fifo_count;
    if_req_ready_o = rst_i & ~flush_i & ~ar_pending & (credits < CW'(DEPTH))
                   & (inflight_q < CW'(MAX_OUTSTANDING));
    req_acc    = if_req_valid_i & if_req_ready_o;
    pop        = fifo_valid & if_resp_ready_i;
    push       = r_hs & ~flush_i & (drop_cnt_q == '0);
    head       = fifo_valid ? mem_q[rd_ptr_q[IW-1:0]] : '0;
  end

  assign if_resp_valid_o = fifo_valid;
  assign if_resp_inst_o  = head[DATA_WIDTH-1:0];
`ifdef IFU_FETCH_ERR_EN
  assign if_resp_err_o   = head[DATA_WIDTH];
`endif
  assign ifu_araddr_o    = araddr_q;
  // Credits reserve a buffer slot for every issued read, so R can always be accepted out of reset
  assign ifu_rready_o    = rst_i;

  // AR state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // AR next state: an accepted request waits in ADDR until the slave takes it, flush or not
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_acc) state_d = ADDR;
      ADDR:    if (ifu_arready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // AR outputs decoded from state
  always_comb begin
    ifu_arvalid_o = (state_q == ADDR);
  end

  // Next values of address, counters and buffer pointers
  always_comb begin
    araddr_d   = req_acc ? if_req_pc_i : araddr_q;
    inflight_d = inflight_q + CW'(ar_hs) - CW'(r_hs);
    drop_cnt_d = drop_cnt_q;
    if (flush_i) begin
      // Everything still owed by the bus is dropped, except a beat arriving right now
      drop_cnt_d = inflight_q + CW'(ar_pending) - CW'(r_hs);
    end else if (r_hs && (drop_cnt_q != '0)) begin
      drop_cnt_d = drop_cnt_q - ONE;
    end
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
    end else if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      araddr_q   <= '0;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      araddr_q   <= araddr_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Response storage; contents are only visible through the occupancy-gated head
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[IW-1:0]] <= wdata;
    end
  end

endmodule

// File: tb/tb_ifu_axi_fetch.sv
// tb/tb_ifu_axi_fetch.sv - directed self-checking bench for ifu_axi_fetch with a queue-based reference model
`timescale 1ns/1ps
module tb_ifu_axi_fetch;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int MAXO = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [AW-1:0] req_pc = '0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [DW-1:0] resp_inst;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic          arvalid;
  logic          arready = 1'b0;
  logic [AW-1:0] araddr;
  logic          rvalid = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic          rready;
  logic [1:0]    rresp = 2'b00;
`ifdef IFU_FETCH_ERR_EN
  logic          resp_err;
`endif

  int vectors = 0;
  int miscompares = 0;

  ifu_axi_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i(clk), .rst_i(rst_n), .flush_i(flush),
    .if_req_pc_i(req_pc), .if_req_valid_i(req_valid), .if_req_ready_o(req_ready),
    .if_resp_inst_o(resp_inst), .if_resp_valid_o(resp_valid), .if_resp_ready_i(resp_ready),
`ifdef IFU_FETCH_ERR_EN
    .ifu_rresp_i(rresp), .if_resp_err_o(resp_err),
`endif
    .ifu_arvalid_o(arvalid), .ifu_arready_i(arready), .ifu_araddr_o(araddr),
    .ifu_rvalid_i(rvalid), .ifu_rdata_i(rdata), .ifu_rready_o(rready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one pending address, a count of reads owed by the bus, a drop count, a response queue
  bit            m_ar_busy = 1'b0;
  logic [AW-1:0] m_ar_addr = '0;
  int            m_out = 0;
  int            m_drop = 0;
  logic [DW:0]   m_fifo[$];

  function automatic bit m_req_ready();
    return rst_n && !flush && !m_ar_busy && (m_out < MAXO) &&
           ((int'(m_ar_busy) + m_out + m_fifo.size()) < DEPTH);
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_ar_busy = 1'b0; m_ar_addr = '0; m_out = 0; m_drop = 0; m_fifo.delete();
      end else begin
        bit acc, arhs, rhs, popv, errb;
        acc  = req_valid && m_req_ready();
        arhs = m_ar_busy && arready;
        rhs  = rvalid && (m_out > 0);
        popv = (m_fifo.size() > 0) && resp_ready;
`ifdef IFU_FETCH_ERR_EN
        errb = (rresp != 2'b00);
`else
        errb = 1'b0;
`endif
        if (flush) begin
          m_fifo.delete();
          m_drop = m_out + int'(m_ar_busy) - int'(rhs);
        end else begin
          if (popv) void'(m_fifo.pop_front());
          if (rhs) begin
            if (m_drop > 0) m_drop--;
            else m_fifo.push_back({errb, rdata});
          end
        end
        m_out = m_out + int'(arhs) - int'(rhs);
        if (acc) begin
          m_ar_busy = 1'b1; m_ar_addr = req_pc;
        end else if (arhs) begin
          m_ar_busy = 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      check("req_ready", req_ready, m_req_ready());
      check("arvalid", arvalid, m_ar_busy);
      if (m_ar_busy) check("araddr", araddr, m_ar_addr);
      check("resp_valid", resp_valid, m_fifo.size() > 0);
      if (m_fifo.size() > 0) begin
        check("resp_inst", resp_inst, m_fifo[0][DW-1:0]);
`ifdef IFU_FETCH_ERR_EN
        check("resp_err", resp_err, m_fifo[0][DW]);
`endif
      end
      check("rready", rready, rst_n);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [AW-1:0] a);
    int n = 0;
    req_pc = a;
    req_valid = 1'b1;
    while (!req_ready && n < 30) begin
      tick();
      n++;
    end
    check("fetch_accept_wait", n < 30, 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic ar_accept();
    int n = 0;
    while (!arvalid && n < 30) begin
      tick();
      n++;
    end
    check("ar_wait", n < 30, 1);
    arready = 1'b1;
    tick();
    arready = 1'b0;
  endtask

  task automatic r_beat(input logic [DW-1:0] d, input logic [1:0] rs);
    rvalid = 1'b1;
    rdata = d;
    rresp = rs;
    tick();
    rvalid = 1'b0;
    rresp = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before 200000ns");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_rready", rready, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_req_ready", req_ready, 1);
    check("post_rst_rready", rready, 1);

    // Single fetch
    fetch(32'h8000_0000);
    check("t1_arvalid", arvalid, 1);
    check("t1_araddr", araddr, 32'h8000_0000);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    tick();
    rvalid = 1'b1;
    rdata = 32'h0000_0013;
    check("t1_valid_in_r_cycle", resp_valid, 0);
    tick();
    rvalid = 1'b0;
    check("t1_valid", resp_valid, 1);
    check("t1_inst", resp_inst, 32'h0000_0013);
    tick();
    check("t1_popped", resp_valid, 0);

    // Back-pressure: four buffered responses exhaust the credits
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fetch(32'h0000_1000 + 32'(4 * i));
      ar_accept();
      r_beat(32'h0000_A000 + 32'(i), 2'b00);
    end
    check("t2_full_ready", req_ready, 0);
    check("t2_head0", resp_inst, 32'h0000_A000);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("t2_ready_after_pop", req_ready, 1);
    resp_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      check("t2_order", resp_inst, 32'h0000_A000 + 32'(i));
      tick();
    end
    check("t2_drained", resp_valid, 0);

    // Flush with two reads owed and one response buffered
    resp_ready = 1'b0;
    fetch(32'h0000_2000);
    ar_accept();
    r_beat(32'h0000_B000, 2'b00);
    fetch(32'h0000_2004);
    ar_accept();
    fetch(32'h0000_2008);
    ar_accept();
    check("t3_buffered", resp_valid, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t3_empty_after_flush", resp_valid, 0);
    r_beat(32'hDEAD_0001, 2'b00);
    r_beat(32'hDEAD_0002, 2'b00);
    check("t3_dropped", resp_valid, 0);
    fetch(32'h0000_200C);
    ar_accept();
    r_beat(32'h0000_B00C, 2'b00);
    check("t3_next_valid", resp_valid, 1);
    check("t3_next_inst", resp_inst, 32'h0000_B00C);
    resp_ready = 1'b1;
    tick();

    // Flush while the address is still waiting for arready
    fetch(32'h0000_3000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_arvalid_held", arvalid, 1);
    check("t4_araddr_held", araddr, 32'h0000_3000);
    tick();
    check("t4_araddr_held2", araddr, 32'h0000_3000);
    ar_accept();
    r_beat(32'hDEAD_0003, 2'b00);
    check("t4_dropped", resp_valid, 0);
    fetch(32'h0000_3004);
    ar_accept();
    r_beat(32'h0000_C004, 2'b00);
    check("t4_next_inst", resp_inst, 32'h0000_C004);
    tick();

    // Asynchronous reset with two reads owed and one response buffered
    resp_ready = 1'b0;
    fetch(32'h0000_4000);
    ar_accept();
    r_beat(32'h0000_D000, 2'b00);
    fetch(32'h0000_4004);
    ar_accept();
    fetch(32'h0000_4008);
    ar_accept();
    check("t5_buffered", resp_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_req_ready", req_ready, 0);
    check("t5_rst_arvalid", arvalid, 0);
    check("t5_rst_araddr", araddr, 0);
    check("t5_rst_resp_valid", resp_valid, 0);
    check("t5_rst_inst", resp_inst, 0);
    check("t5_rst_rready", rready, 0);
    tick();
    rst_n = 1'b1;
    resp_ready = 1'b1;
    #1;
    check("t5_release_ready", req_ready, 1);
    r_beat(32'hDEAD_0004, 2'b00);
    r_beat(32'hDEAD_0005, 2'b00);
    check("t5_stale_hidden", resp_valid, 0);
    fetch(32'h0000_5000);
    ar_accept();
    r_beat(32'h0000_E000, 2'b00);
    check("t5_fresh_valid", resp_valid, 1);
    check("t5_fresh_inst", resp_inst, 32'h0000_E000);
    tick();

`ifdef IFU_FETCH_ERR_EN
    // Error status travels with its own instruction only
    fetch(32'h0000_6000);
    ar_accept();
    r_beat(32'h0000_F000, 2'b10);
    check("t6_err_inst", resp_inst, 32'h0000_F000);
    check("t6_err_set", resp_err, 1);
    tick();
    fetch(32'h0000_6004);
    ar_accept();
    r_beat(32'h0000_F004, 2'b00);
    check("t6_ok_inst", resp_inst, 32'h0000_F004);
    check("t6_err_clear", resp_err, 0);
    tick();
`endif

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
